// File: rtl/popcount_sched_pkg.sv
// Shared types and helpers for the popcount scheduler: FSM states,
// width helper and the round-robin pick used by the requester arbiter.
package popcount_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest requester vector the pick function handles.
  localparam int RR_MAX = 32;

  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // First valid index at or after ptr, wrapping modulo n, as a one-hot vector.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                                input int ptr, input int n);
    logic [RR_MAX-1:0] oh;
    logic              found;
    int                idx;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (i < n && !found && valid[idx[4:0]]) begin
        oh[idx[4:0]] = 1'b1;
        found        = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/popcount_sched_popcount8.sv
// popcount8: combinational set-bit count of one byte; output forced to zero
// when en is low.
module popcount8 (
  input  logic       en,
  input  logic [7:0] din,
  output logic [3:0] cnt
);

  always_comb begin
    cnt = '0;
    if (en) begin
      for (int b = 0; b < 8; b++) cnt = cnt + {3'b000, din[b]};
    end
  end

endmodule

// File: rtl/popcount_sched.sv
// popcount_sched: round-robin shared byte-lane popcount engine with a
// valid/ready result channel. Optional threshold compare: POPCOUNT_SCHED_THRESH_EN.
module popcount_sched
  import popcount_sched_pkg::*;
#(
  parameter  int NREQ   = 2,
  parameter  int WORD_W = 64,
  parameter  int LANES  = 2,
  localparam int STEPS  = WORD_W / (8 * LANES),
  localparam int CNT_W  = $clog2(WORD_W + 1),
  localparam int ID_W   = clog2w(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*WORD_W-1:0] req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [CNT_W-1:0]       rsp_cnt,
  output logic                   busy
`ifdef POPCOUNT_SCHED_THRESH_EN
  ,
  input  logic [CNT_W-1:0]       thresh,
  output logic                   rsp_over
`endif
);

  localparam int STEP_W = clog2w(STEPS);

  if (WORD_W % (8 * LANES) != 0) begin : g_bad_word_w
    $error("popcount_sched: WORD_W must be a multiple of 8*LANES");
  end
  if (NREQ < 1 || NREQ > RR_MAX) begin : g_bad_nreq
    $error("popcount_sched: NREQ out of range");
  end

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr, id_q, grant_id;
  logic [CNT_W-1:0]    acc, lane_sum;
  logic [STEP_W-1:0]   step;
  logic [WORD_W-1:0]   word_q, sel_word;
  logic [RR_MAX-1:0]   pick_oh;
  logic                unused_pick;
  logic                grant_hs, last_step;
  logic [3:0]          lane_cnt [LANES];

  assign pick_oh     = rr_pick(RR_MAX'(req_valid), int'(rr_ptr), NREQ);
  assign unused_pick = ^pick_oh;
  assign grant_hs    = |(req_valid & req_ready);
  assign last_step   = (step == STEP_W'(STEPS - 1));

  always_comb begin
    grant_id = '0;
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        grant_id = ID_W'(i);
        sel_word = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  // Engine: LANES byte cells over the low bytes of the shifting latched word.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    popcount8 u_pc (
      .en  (1'b1),
      .din (word_q[l*8 +: 8]),
      .cnt (lane_cnt[l])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) lane_sum = lane_sum + CNT_W'(lane_cnt[l]);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_hs)  state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE && en) ? pick_oh[NREQ-1:0] : '0;
    rsp_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      step   <= '0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else begin
      case (state_q)
        IDLE: if (grant_hs) begin
          acc  <= '0;
          step <= '0;
          id_q <= grant_id;
        end
        RUN: begin
          acc  <= acc + lane_sum;
          step <= step + 1'b1;
        end
        DONE: if (rsp_ready) begin
          rr_ptr <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Word is consumed LSB byte first by shifting it down each RUN cycle.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && grant_hs) word_q <= sel_word;
    else if (state_q == RUN)         word_q <= word_q >> (8 * LANES);
  end

  assign rsp_cnt = acc;
  assign rsp_id  = id_q;

`ifdef POPCOUNT_SCHED_THRESH_EN
  logic [CNT_W-1:0] thresh_q;

  always_ff @(posedge clk) begin
    if (rst)                              thresh_q <= '0;
    else if (state_q == IDLE && grant_hs) thresh_q <= thresh;
  end

  assign rsp_over = (state_q == DONE) && (acc >= thresh_q);
`endif

endmodule

// File: tb/tb_popcount_sched.sv
// Scoreboard bench for popcount_sched: a reference model predicts grants and
// queues expected results; a negedge monitor compares DUT outputs.
module tb_popcount_sched;

  localparam int NREQ   = 2;
  localparam int WORD_W = 64;
  localparam int LANES  = 2;
  localparam int STEPS  = WORD_W / (8 * LANES);
  localparam int CNT_W  = $clog2(WORD_W + 1);
  localparam int ID_W   = 1;

  logic                   clk = 1'b0;
  logic                   rst, en, rsp_ready;
  logic [NREQ-1:0]        req_valid, req_ready;
  logic [NREQ*WORD_W-1:0] req_data;
  logic                   rsp_valid, busy;
  logic [ID_W-1:0]        rsp_id;
  logic [CNT_W-1:0]       rsp_cnt;
  logic [CNT_W-1:0]       thresh;
`ifdef POPCOUNT_SCHED_THRESH_EN
  logic                   rsp_over;
`endif

  always #5 clk = ~clk;

  popcount_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .LANES(LANES)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_cnt   (rsp_cnt),
    .busy      (busy)
`ifdef POPCOUNT_SCHED_THRESH_EN
    ,
    .thresh    (thresh),
    .rsp_over  (rsp_over)
`endif
  );

  typedef struct {
    int id;
    int cnt;
    bit over;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   age      = -1;
  int   mptr     = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] model_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (v[idx]) return NREQ'(1) << idx;
    end
    return '0;
  endfunction

  // Reference model and monitor: engine is free, or a job granted age cycles ago.
  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] er;
    exp_t            e;
    if (rst) begin
      sb.delete();
      age  = -1;
      mptr = 0;
    end else begin
      if (age >= 0) age++;
      er = (age < 0 && en) ? model_pick(req_valid, mptr) : '0;
      chk("req_ready", req_ready, er);
      chk("busy", busy, age >= 0);
      chk("rsp_valid", rsp_valid, age >= STEPS + 1);
      if (age >= STEPS + 1) begin
        chk("rsp_id", rsp_id, sb[0].id);
        chk("rsp_cnt", rsp_cnt, sb[0].cnt);
`ifdef POPCOUNT_SCHED_THRESH_EN
        chk("rsp_over", rsp_over, sb[0].over);
`endif
        if (rsp_ready) begin
          mptr = (sb[0].id + 1) % NREQ;
          void'(sb.pop_front());
          age = -1;
        end
      end
      if ((req_valid & er) != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (er[i]) begin
            e.id   = i;
            e.cnt  = $countones(req_data[i*WORD_W +: WORD_W]);
            e.over = (e.cnt >= int'(thresh));
          end
        end
        sb.push_back(e);
        age = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_idle timeout after %0d cycles (required < %0d)", n, budget);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*WORD_W +: WORD_W] = {$urandom, $urandom};
  endtask

  task automatic do_job(input int i, input logic [WORD_W-1:0] w);
    int n = 0;
    req_data[i*WORD_W +: WORD_W] = w;
    req_valid[i] = 1'b1;
    #1;
    while (!req_ready[i] && n < 50) begin
      cyc();
      #1;
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL grant timeout requester=%0d waited=%0d cycles", i, n);
    end
    cyc();
    req_valid[i] = 1'b0;
    rand_data();
    wait_idle(50);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WORD_W-1:0] ones;
    ones      = '1;
    rst       = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    thresh    = '0;
    repeat (3) cyc();
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_cnt", rsp_cnt, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_req_ready", req_ready, 0);
    rst = 1'b0;
    en  = 1'b1;

    do_job(0, 64'hFFFF_0000_0F0F_0001);
    do_job(0, '0);
    do_job(0, ones);
    thresh = CNT_W'(29);
    do_job(1, 64'h0000_0000_1FFF_FFFF);
    thresh = CNT_W'(30);
    do_job(1, 64'h0000_0000_1FFF_FFFF);

    // Both requesters continuously valid with changing data.
    req_valid = '1;
    repeat (40) begin
      rand_data();
      cyc();
    end
    req_valid = '0;
    wait_idle(50);

    // Backpressure while DONE.
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (STEPS + 1 + 10) begin
      rand_data();
      cyc();
    end
    rsp_ready = 1'b1;
    repeat (12) cyc();
    req_valid = '0;
    wait_idle(50);

    // Grants blocked while en is low.
    en        = 1'b0;
    req_valid = '1;
    repeat (20) cyc();
    en = 1'b1;
    cyc();
    req_valid = '0;
    wait_idle(50);

    // Reset during RUN discards the job and restores the pointer.
    do_job(0, {$urandom, $urandom});
    req_valid = '1;
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_cnt", rsp_cnt, 0);
    rst       = 1'b0;
    req_valid = '1;
    #1;
    chk("post_reset_grant", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    wait_idle(50);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      rand_data();
      en        = ($urandom % 10) != 0;
      rsp_ready = ($urandom % 10) < 7;
      thresh    = CNT_W'($urandom_range(0, WORD_W));
      cyc();
    end
    en        = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(100);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
